// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern encodings,
// colour-bar table, run-state encoding and standard timing presets.
package video_pkg;

    typedef enum logic [2:0] {
        PAT_COLOUR_BAR = 3'd0,
        PAT_GRID       = 3'd1,
        PAT_GRAY_RAMP  = 3'd2,
        PAT_SOLID      = 3'd3,
        PAT_MOVING_BAR = 3'd4
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Entry 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_COLOURS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    localparam logic [23:0] MOVE_BAR_FG   = 24'hFFFFFF;
    localparam logic [23:0] MOVE_BAR_BG   = 24'h000080;
    localparam int          MOVE_BAR_W    = 16;
    localparam int          MOVE_BAR_STEP = 4;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t TIMING_720P60  = '{1280, 110, 40, 220, 720, 5, 5, 20};
    localparam timing_t TIMING_1080P60 = '{1920, 88, 44, 148, 1080, 4, 5, 36};
    localparam timing_t TIMING_480P60  = '{640, 16, 96, 48, 480, 10, 2, 33};

endpackage

// File: rtl/video_timing_core.sv
// Raster counters with an IDLE/RUN controller; produces unregistered sync,
// data-enable and active position for the current counter state.
module video_timing_core
    import video_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 13
) (
    input  logic          pixel_clk,
    input  logic          sys_rst,
    input  logic          enable,
    output logic          tm_hs,
    output logic          tm_vs,
    output logic          tm_de,
    output logic [CW-1:0] tm_x,
    output logic [CW-1:0] tm_y,
    output logic          tm_frame_start,
    output logic          tm_running
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BP + V_ACTIVE);

    run_state_e    state_reg, state_next;
    logic [CW-1:0] h_cnt_reg, v_cnt_reg;
    logic          line_end, frame_end, h_act, v_act;

    assign line_end  = (h_cnt_reg == H_LAST);
    assign frame_end = line_end && (v_cnt_reg == V_LAST);
    assign h_act     = (h_cnt_reg >= H_ACT_BEG) && (h_cnt_reg < H_ACT_END);
    assign v_act     = (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END);

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // enable only matters at the idle point or the last cycle of a frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (enable) state_next = ST_RUN;
            ST_RUN:  if (frame_end && !enable) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (state_reg != ST_RUN) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (line_end) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + CW'(1);
        end else begin
            h_cnt_reg <= h_cnt_reg + CW'(1);
        end
    end

    always_comb begin
        tm_hs          = ~HS_POL;
        tm_vs          = ~VS_POL;
        tm_de          = 1'b0;
        tm_x           = '0;
        tm_y           = '0;
        tm_frame_start = 1'b0;
        tm_running     = 1'b0;
        if (state_reg == ST_RUN) begin
            tm_hs          = (h_cnt_reg < H_SYNC_END) ? HS_POL : ~HS_POL;
            tm_vs          = (v_cnt_reg < V_SYNC_END) ? VS_POL : ~VS_POL;
            tm_de          = h_act && v_act;
            tm_frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
            tm_running     = 1'b1;
            if (h_act && v_act) begin
                tm_x = h_cnt_reg - H_ACT_BEG;
                tm_y = v_cnt_reg - V_ACT_BEG;
            end
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Programmable-timing test pattern source for a parallel RGB HDMI transmitter:
// timing core, per-frame pattern latch, pattern mux and aligned output registers.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = TIMING_720P60.h_active,
    parameter int H_FP     = TIMING_720P60.h_fp,
    parameter int H_SYNC   = TIMING_720P60.h_sync,
    parameter int H_BP     = TIMING_720P60.h_bp,
    parameter int V_ACTIVE = TIMING_720P60.v_active,
    parameter int V_FP     = TIMING_720P60.v_fp,
    parameter int V_SYNC   = TIMING_720P60.v_sync,
    parameter int V_BP     = TIMING_720P60.v_bp,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 13
) (
    input  logic          pixel_clk,
    input  logic          sys_rst,
    input  logic          enable,
    input  logic [2:0]    pattern_mode,
    input  logic [23:0]   solid_rgb,
    output logic          video_hs,
    output logic          video_vs,
    output logic          video_de,
    output logic [23:0]   video_rgb,
    output logic [CW-1:0] pixel_xpos,
    output logic [CW-1:0] pixel_ypos,
    output logic          frame_start,
    output logic          running
);

    logic          t_hs, t_vs, t_de, t_fs, t_run;
    logic [CW-1:0] t_x, t_y;

    video_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
    ) u_timing (
        .pixel_clk      (pixel_clk),
        .sys_rst        (sys_rst),
        .enable         (enable),
        .tm_hs          (t_hs),
        .tm_vs          (t_vs),
        .tm_de          (t_de),
        .tm_x           (t_x),
        .tm_y           (t_y),
        .tm_frame_start (t_fs),
        .tm_running     (t_run)
    );

    logic [2:0]    mode_reg;
    logic [23:0]   solid_reg;
    logic [7:0]    frame_cnt_reg;
    logic [CW-1:0] bar_x_reg, bar_x_sum, bar_x_step;
    logic          started_reg;

    // bar_x tracks (frame_cnt*4) mod H_ACTIVE incrementally; it restarts when frame_cnt wraps.
    assign bar_x_sum  = bar_x_reg + CW'(MOVE_BAR_STEP);
    assign bar_x_step = (bar_x_sum >= CW'(H_ACTIVE)) ? bar_x_sum - CW'(H_ACTIVE) : bar_x_sum;

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_reg      <= '0;
            solid_reg     <= '0;
            frame_cnt_reg <= '0;
            bar_x_reg     <= '0;
            started_reg   <= 1'b0;
        end else if (t_fs) begin
            mode_reg  <= pattern_mode;
            solid_reg <= solid_rgb;
            if (started_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
                bar_x_reg     <= (frame_cnt_reg == 8'hFF) ? '0 : bar_x_step;
            end else begin
                started_reg <= 1'b1;
            end
        end
    end

    // Bar boundaries: x*8/H_ACTIVE >= k  <=>  x >= ceil(k*H_ACTIVE/8).
    logic [7:1] bar_ge;
    logic [2:0] bar_idx;
    genvar gi;
    for (gi = 1; gi < 8; gi++) begin : g_bar_edge
        assign bar_ge[gi] = (t_x >= CW'((gi * H_ACTIVE + 7) / 8));
    end

    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (bar_ge[k]) bar_idx = 3'(k);
        end
    end

    logic [CW-1:0] bar_dist;
    logic [23:0]   pix_rgb;

    assign bar_dist = t_x - bar_x_reg;

    always_comb begin
        pix_rgb = '0;
        case (pattern_e'(mode_reg))
            PAT_COLOUR_BAR: pix_rgb = BAR_COLOURS[bar_idx];
            PAT_GRID:       pix_rgb = (t_x[4:0] == 5'd0 || t_y[4:0] == 5'd0) ? 24'hFFFFFF : 24'h000000;
            PAT_GRAY_RAMP:  pix_rgb = {3{t_x[7:0]}};
            PAT_SOLID:      pix_rgb = solid_reg;
            PAT_MOVING_BAR: pix_rgb = (bar_dist < CW'(MOVE_BAR_W)) ? MOVE_BAR_FG : MOVE_BAR_BG;
            default:        pix_rgb = '0;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            video_hs    <= t_hs;
            video_vs    <= t_vs;
            video_de    <= t_de;
            video_rgb   <= t_de ? pix_rgb : 24'h000000;
            pixel_xpos  <= t_x;
            pixel_ypos  <= t_y;
            frame_start <= t_fs;
            running     <= t_run;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised bench for video_pattern_gen on a tiny raster, compared cycle by
// cycle against a frame-position reference model.
module tb_video_pattern_gen;

    localparam int HA = 16, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int CW = 13;

    localparam logic [23:0] BAR_COL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          pixel_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          enable = 1'b0;
    logic [2:0]    pattern_mode = 3'd0;
    logic [23:0]   solid_rgb = 24'h0;
    logic          video_hs, video_vs, video_de, frame_start, running;
    logic [23:0]   video_rgb;
    logic [CW-1:0] pixel_xpos, pixel_ypos;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
    ) dut (
        .pixel_clk    (pixel_clk),
        .sys_rst      (sys_rst),
        .enable       (enable),
        .pattern_mode (pattern_mode),
        .solid_rgb    (solid_rgb),
        .video_hs     (video_hs),
        .video_vs     (video_vs),
        .video_de     (video_de),
        .video_rgb    (video_rgb),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .frame_start  (frame_start),
        .running      (running)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state: frame position counts cycles since frame start.
    bit          m_run, m_started;
    int          m_pos, m_fc, m_mode;
    logic [23:0] m_solid;
    bit          e_hs, e_vs, e_de, e_fs, e_run;
    int          e_x, e_y;
    logic [23:0] e_rgb;

    function automatic logic [23:0] ref_pixel(int mode, logic [23:0] solid, int fc, int x, int y);
        logic [7:0] g;
        int bar;
        g = 8'(x % 256);
        bar = (fc * 4) % HA;
        case (mode)
            0: return BAR_COL[3'(x * 8 / HA)];
            1: return ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
            2: return {g, g, g};
            3: return solid;
            4: return (((x - bar) & 8191) < 16) ? 24'hFFFFFF : 24'h000080;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic expect_idle();
        e_hs = !HSP; e_vs = !VSP; e_de = 0; e_fs = 0; e_run = 0;
        e_x = 0; e_y = 0; e_rgb = 24'h0;
    endtask

    task automatic model_reset();
        m_run = 0; m_started = 0; m_pos = 0; m_fc = 0; m_mode = 0; m_solid = 24'h0;
    endtask

    // Expected outputs after the coming edge, then advance the model by one cycle.
    task automatic model_edge();
        int h, v;
        expect_idle();
        if (sys_rst) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            m_run = enable;
            m_pos = 0;
            return;
        end
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) begin
            m_mode = 32'(pattern_mode);
            m_solid = solid_rgb;
            if (m_started) m_fc = (m_fc + 1) % 256;
            m_started = 1;
        end
        e_hs  = (h < HS) ? HSP : !HSP;
        e_vs  = (v < VS) ? VSP : !VSP;
        e_de  = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        e_fs  = (m_pos == 0);
        e_run = 1;
        if (e_de) begin
            e_x = h - (HS + HB);
            e_y = v - (VS + VB);
            e_rgb = ref_pixel(m_mode, m_solid, m_fc, e_x, e_y);
        end
        if (m_pos == FRAME - 1) begin
            m_pos = 0;
            if (!enable) m_run = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic compare_all(input string phase);
        check({phase, ".hs"},   32'(video_hs),    32'(e_hs));
        check({phase, ".vs"},   32'(video_vs),    32'(e_vs));
        check({phase, ".de"},   32'(video_de),    32'(e_de));
        check({phase, ".rgb"},  32'(video_rgb),   32'(e_rgb));
        check({phase, ".xpos"}, 32'(pixel_xpos),  32'(e_x));
        check({phase, ".ypos"}, 32'(pixel_ypos),  32'(e_y));
        check({phase, ".fs"},   32'(frame_start), 32'(e_fs));
        check({phase, ".run"},  32'(running),     32'(e_run));
    endtask

    task automatic tick(input string phase);
        model_edge();
        @(posedge pixel_clk);
        #1;
        compare_all(phase);
    endtask

    // Run until the model is about to start a new frame (bounded by one frame).
    task automatic align_frame(input string phase);
        for (int i = 0; i < FRAME && !(m_run && m_pos == 0); i++) tick(phase);
    endtask

    initial begin
        model_reset();
        #1 sys_rst = 1'b1;
        #1;
        expect_idle();
        compare_all("reset");
        repeat (3) tick("reset");
        sys_rst = 1'b0;
        repeat (2) tick("idle");

        enable = 1'b1;
        pattern_mode = 3'd0;
        repeat (FRAME + 40) tick("bar");

        pattern_mode = 3'd3;
        solid_rgb = 24'h123456;
        align_frame("solid");
        repeat (80) tick("solid");
        solid_rgb = 24'hABCDEF;
        repeat (2 * FRAME) tick("solid");

        pattern_mode = 3'd4;
        align_frame("move");
        repeat (3 * FRAME) tick("move");

        pattern_mode = 3'd1;
        align_frame("grid");
        repeat (FRAME) tick("grid");
        pattern_mode = 3'd2;
        repeat (FRAME) tick("ramp");

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) pattern_mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) solid_rgb = 24'($urandom);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            tick("rand");
        end

        enable = 1'b1;
        pattern_mode = 3'd0;
        repeat (FRAME + 5) tick("stop");
        align_frame("stop");
        repeat (60) tick("stop");
        enable = 1'b0;
        repeat (FRAME + 30) tick("stop");

        enable = 1'b1;
        pattern_mode = 3'd4;
        repeat (50) tick("arst");
        #2 sys_rst = 1'b1;
        #1;
        expect_idle();
        compare_all("arst_async");
        model_reset();
        repeat (2) tick("arst");
        sys_rst = 1'b0;
        repeat (FRAME + 20) tick("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
